// File: rtl/bus_pkg.sv
// Shared constants and helpers for the registered common bus.
package bus_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    localparam int MAX_SRC = 15;

    function automatic int sel_width(input int num_src);
        return $clog2(num_src + 1);
    endfunction

    // Index 0 is idle and maps to no grant; index k sets bit k-1.
    function automatic logic [MAX_SRC-1:0] idx_to_onehot(input logic [3:0] idx);
        logic [MAX_SRC-1:0] oh;
        oh = '0;
        if (idx != 4'd0)
            oh = MAX_SRC'(1) << (idx - 4'd1);
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational winner select: lock hold by the current owner, else round-robin from ptr+1.
module rr_arbiter
    import bus_pkg::*;
#(
    parameter  int NUM_SRC = 7,
    localparam int SEL_W   = sel_width(NUM_SRC)
) (
    input  logic               en,
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] lock,
    input  logic [SEL_W-1:0]   owner,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   win
);

    int o;
    int p;
    int cand;

    always_comb begin
        win  = '0;
        o    = int'(owner);
        p    = int'(ptr);
        cand = 0;
        if (en) begin
            if (o >= 1 && o <= NUM_SRC && req[o-1] && lock[o-1]) begin
                win = owner;
            end else begin
                // Walk NUM_SRC candidates starting just after the pointer, wrapping to 1.
                for (int i = 1; i <= NUM_SRC; i++) begin
                    cand = ((p + i - 1) % NUM_SRC) + 1;
                    if (win == '0 && req[cand-1])
                        win = SEL_W'(cand);
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Registered common bus: direct 3-bit select or round-robin arbitration with lock.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter  int DATA_W  = 16,
    parameter  int NUM_SRC = 7,
    localparam int SEL_W   = sel_width(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode_i,
    input  logic [SEL_W-1:0]          sel_i,
    input  logic [NUM_SRC-1:0]        req_i,
    input  logic [NUM_SRC-1:0]        lock_i,
    input  logic [NUM_SRC*DATA_W-1:0] data_i,
    output logic [DATA_W-1:0]         bus_o,
    output logic                      bus_valid_o,
    output logic [SEL_W-1:0]          bus_src_o,
    output logic [NUM_SRC-1:0]        gnt_o
);

    logic [NUM_SRC-1:0][DATA_W-1:0] src_data;
    logic [SEL_W-1:0]               ptr_q;
    logic [SEL_W-1:0]               owner_q;
    logic [SEL_W-1:0]               rr_win;
    logic [SEL_W-1:0]               nxt_src;
    logic [DATA_W-1:0]              nxt_bus;
    logic [MAX_SRC-1:0]             nxt_oh;

    assign src_data = data_i;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .en    (mode_i == MODE_RR),
        .req   (req_i),
        .lock  (lock_i),
        .owner (owner_q),
        .ptr   (ptr_q),
        .win   (rr_win)
    );

    always_comb begin
        nxt_src = '0;
        if (mode_i == MODE_DIRECT) begin
            if (sel_i != '0 && int'(sel_i) <= NUM_SRC)
                nxt_src = sel_i;
        end else begin
            nxt_src = rr_win;
        end
        nxt_bus = '0;
        if (nxt_src != '0)
            nxt_bus = src_data[nxt_src - SEL_W'(1)];
        nxt_oh = idx_to_onehot(4'(nxt_src));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_o       <= '0;
            bus_valid_o <= 1'b0;
            bus_src_o   <= '0;
            gnt_o       <= '0;
            ptr_q       <= SEL_W'(NUM_SRC);
            owner_q     <= '0;
        end else begin
            bus_o       <= nxt_bus;
            bus_valid_o <= (nxt_src != '0);
            bus_src_o   <= nxt_src;
            gnt_o       <= nxt_oh[NUM_SRC-1:0];
            // Ownership (and thus any lock) exists only across arbitrated cycles.
            owner_q     <= (mode_i == MODE_RR) ? nxt_src : '0;
            if (nxt_src != '0)
                ptr_q <= nxt_src;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed table-driven bench for bus_arbiter with NUM_SRC=7, DATA_W=16.
module tb_bus_arbiter;

    localparam int DATA_W  = 16;
    localparam int NUM_SRC = 7;
    localparam int SEL_W   = 3;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      mode_i;
    logic [SEL_W-1:0]          sel_i;
    logic [NUM_SRC-1:0]        req_i;
    logic [NUM_SRC-1:0]        lock_i;
    logic [NUM_SRC*DATA_W-1:0] data_i;
    logic [DATA_W-1:0]         bus_o;
    logic                      bus_valid_o;
    logic [SEL_W-1:0]          bus_src_o;
    logic [NUM_SRC-1:0]        gnt_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode_i      (mode_i),
        .sel_i       (sel_i),
        .req_i       (req_i),
        .lock_i      (lock_i),
        .data_i      (data_i),
        .bus_o       (bus_o),
        .bus_valid_o (bus_valid_o),
        .bus_src_o   (bus_src_o),
        .gnt_o       (gnt_o)
    );

    typedef struct {
        logic               rst_n;
        logic               mode;
        logic [SEL_W-1:0]   sel;
        logic [NUM_SRC-1:0] req;
        logic [NUM_SRC-1:0] lock;
        int                 exp_src;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one vector before the edge, then check the registered result just after it.
    task automatic apply(input vec_t v, input int idx);
        int exp_bus;
        int exp_gnt;
        @(negedge clk);
        rst_n  = v.rst_n;
        mode_i = v.mode;
        sel_i  = v.sel;
        req_i  = v.req;
        lock_i = v.lock;
        @(posedge clk);
        #1;
        exp_bus = (v.exp_src == 0) ? 0 : 'hA000 + v.exp_src;
        exp_gnt = (v.exp_src == 0) ? 0 : (1 << (v.exp_src - 1));
        chk($sformatf("v%0d.src", idx),   int'(bus_src_o),   v.exp_src);
        chk($sformatf("v%0d.valid", idx), int'(bus_valid_o), (v.exp_src != 0) ? 1 : 0);
        chk($sformatf("v%0d.bus", idx),   int'(bus_o),       exp_bus);
        chk($sformatf("v%0d.gnt", idx),   int'(gnt_o),       exp_gnt);
    endtask

    initial begin
        for (int k = 1; k <= NUM_SRC; k++)
            data_i[(k-1)*DATA_W +: DATA_W] = 16'hA000 + 16'(k);
        rst_n = 1'b0; mode_i = 1'b1; sel_i = '0; req_i = '0; lock_i = '0;

        // reset, then first grant from source 1
        tbl.push_back('{1'b0, 1'b1, 3'd0, 7'h7F, 7'h00, 0});
        tbl.push_back('{1'b0, 1'b1, 3'd0, 7'h7F, 7'h00, 0});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 7'h7F, 7'h00, 1});
        // direct select 3, idle, 7
        tbl.push_back('{1'b1, 1'b0, 3'd3, 7'h00, 7'h00, 3});
        tbl.push_back('{1'b1, 1'b0, 3'd0, 7'h7F, 7'h7F, 0});
        tbl.push_back('{1'b1, 1'b0, 3'd7, 7'h00, 7'h00, 7});
        // round-robin over 2,4,7 starting after pointer 7
        tbl.push_back('{1'b1, 1'b1, 3'd0, 7'b1001010, 7'h00, 2});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 7'b1001010, 7'h00, 4});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 7'b1001010, 7'h00, 7});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 7'b1001010, 7'h00, 2});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 7'b1001010, 7'h00, 4});
        // source 4 locked against source 5, then drops req
        tbl.push_back('{1'b1, 1'b1, 3'd0, 7'b0011000, 7'b0001000, 4});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 7'b0011000, 7'b0001000, 4});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 7'b0011000, 7'b0001000, 4});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 7'b0010000, 7'b0001000, 5});
        // owner 6 locked, direct override, back to arbitration, idle, pointer kept at 6
        tbl.push_back('{1'b1, 1'b1, 3'd0, 7'b0100000, 7'b0100000, 6});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 7'b0100000, 7'b0100000, 6});
        tbl.push_back('{1'b1, 1'b0, 3'd1, 7'b0100000, 7'b0100000, 1});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 7'b0100000, 7'b0000000, 6});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 7'b0000000, 7'b0000000, 0});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 7'b1000011, 7'b0000000, 7});
        // lock must not survive a direct cycle: 7 was owner with lock, direct 2, then 1 and 7 request
        tbl.push_back('{1'b1, 1'b0, 3'd2, 7'b1000001, 7'b1000000, 2});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 7'b1000001, 7'b1000000, 7});
        tbl.push_back('{1'b1, 1'b1, 3'd0, 7'b1000001, 7'b1000000, 7});

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

        // reset while source 3 holds a lock; afterwards source 1 wins from the reset pointer
        apply('{1'b1, 1'b1, 3'd0, 7'b0000100, 7'b0000100, 3}, 100);
        apply('{1'b1, 1'b1, 3'd0, 7'b0000101, 7'b0000100, 3}, 101);
        apply('{1'b0, 1'b1, 3'd0, 7'b0000101, 7'b0000100, 0}, 102);
        apply('{1'b1, 1'b1, 3'd0, 7'b0000101, 7'b0000100, 1}, 103);
        apply('{1'b1, 1'b1, 3'd0, 7'b0000101, 7'b0000000, 3}, 104);

        // wrap: pointer at 7 scans from 1
        apply('{1'b1, 1'b0, 3'd7, 7'b0000000, 7'b0000000, 7}, 105);
        apply('{1'b1, 1'b1, 3'd0, 7'b1000010, 7'b0000000, 2}, 106);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
